// File: rtl/ov7670_pixel_capture.sv
// OV7670 RGB565 capture: byte pairing, 2:1 decimation and frame-buffer write strobes.
// Optional build macro CAPTURE_TEST_PATTERN_EN replaces camera pixels with 8 colour bars.
module ov7670_pixel_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 2,
  parameter int ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              href,
  input  logic              vsync,
  input  logic [7:0]        data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [15:0]       wdata,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              line_err,
  output logic              frame_err
);

  localparam int XW      = $clog2(H_ACTIVE + 1) + 1;
  localparam int BW      = $clog2(2 * H_ACTIVE + 2) + 1;
  localparam int YW      = $clog2(V_ACTIVE + 2) + 1;
  localparam int OUT_W   = H_ACTIVE / DECIM;
  localparam int OUT_PIX = OUT_W * (V_ACTIVE / DECIM);

  localparam logic [XW-1:0]     X_LIM    = XW'(H_ACTIVE);
  localparam logic [BW-1:0]     B_LINE   = BW'(2 * H_ACTIVE);
  localparam logic [BW-1:0]     B_SAT    = BW'(2 * H_ACTIVE + 1);
  localparam logic [YW-1:0]     Y_LIM    = YW'(V_ACTIVE);
  localparam logic [YW-1:0]     Y_SAT    = YW'(V_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(OUT_PIX - 1);

  typedef enum logic [1:0] {S_SYNC_LO, S_SYNC_HI, S_ARMED, S_LINE} state_t;

  state_t            r_state;
  logic              r_href, r_href_d, r_vsync, r_vsync_d;
  logic [7:0]        r_data, r_hi;
  logic              r_phase;
  logic [XW-1:0]     r_x;
  logic [BW-1:0]     r_bytes;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr;

  logic              w_href_rise, w_href_fall, w_vs_rise, w_vs_fall;
  logic              w_phase, w_x_keep, w_y_keep, w_store, w_line_bad;
  logic [YW-1:0]     w_y_close;
  logic [15:0]       w_pix;

  assign w_href_rise = r_href & ~r_href_d;
  assign w_href_fall = ~r_href & r_href_d;
  assign w_vs_rise   = r_vsync & ~r_vsync_d;
  assign w_vs_fall   = ~r_vsync & r_vsync_d;

  // A new line always starts on the high byte, whatever the previous line left behind.
  assign w_phase  = r_phase & ~w_href_rise;
  assign w_x_keep = (DECIM == 1) || (r_x[0] == 1'b0);
  assign w_y_keep = (DECIM == 1) || (r_y[0] == 1'b0);
  assign w_store  = r_href & w_phase & w_x_keep & w_y_keep & (r_x < X_LIM) & (r_y < Y_LIM);

  // Frame close may coincide with a line close; that line is counted before the check.
  always_comb begin
    w_y_close  = r_y;
    w_line_bad = r_href;
    if (w_href_fall) begin
      if (r_y != Y_SAT) w_y_close = r_y + YW'(1);
      if (r_bytes != B_LINE) w_line_bad = 1'b1;
    end
  end

`ifdef CAPTURE_TEST_PATTERN_EN
  localparam int DSH = (DECIM == 2) ? 1 : 0;
  logic [XW-1:0] w_xs;
  logic [6:0]    w_bar_ge;
  logic [2:0]    w_bar;

  assign w_xs = r_x >> DSH;

  // Bar index = number of bar boundaries the stored column has passed.
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar
      localparam logic [XW+2:0] TH = (XW + 3)'(gi * OUT_W);
      assign w_bar_ge[gi-1] = ({w_xs, 3'b000} >= TH);
    end
  endgenerate

  always_comb begin
    w_bar = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (w_bar_ge[i]) w_bar = 3'(i + 1);
    end
  end

  always_comb begin
    case (w_bar)
      3'd0:    w_pix = 16'hFFFF;
      3'd1:    w_pix = 16'hFFE0;
      3'd2:    w_pix = 16'h07FF;
      3'd3:    w_pix = 16'h07E0;
      3'd4:    w_pix = 16'hF81F;
      3'd5:    w_pix = 16'hF800;
      3'd6:    w_pix = 16'h001F;
      default: w_pix = 16'h0000;
    endcase
  end
`else
  assign w_pix = {r_hi, r_data};
`endif

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state    <= S_SYNC_LO;
      r_href     <= 1'b0;
      r_href_d   <= 1'b0;
      r_vsync    <= 1'b0;
      r_vsync_d  <= 1'b0;
      r_data     <= '0;
      r_hi       <= '0;
      r_phase    <= 1'b0;
      r_x        <= '0;
      r_bytes    <= '0;
      r_y        <= '0;
      r_addr     <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_href     <= href;
      r_vsync    <= vsync;
      r_data     <= data;
      r_href_d   <= r_href;
      r_vsync_d  <= r_vsync;
      we         <= 1'b0;
      frame_done <= 1'b0;

      case (r_state)
        S_SYNC_LO: if (w_vs_rise) r_state <= S_SYNC_HI;
        S_SYNC_HI: if (w_vs_fall) r_state <= S_ARMED;
        S_ARMED: begin
          if (w_vs_fall) begin
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_bytes   <= '0;
            r_phase   <= 1'b0;
            r_addr    <= '0;
            r_state   <= S_LINE;
          end
        end
        S_LINE: begin
          if (w_vs_rise) begin
            if (w_line_bad) line_err <= 1'b1;
            if (w_y_close == Y_LIM) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
            end else begin
              frame_err <= 1'b1;
            end
            r_y     <= w_y_close;
            r_x     <= '0;
            r_bytes <= '0;
            r_phase <= 1'b0;
            r_state <= S_ARMED;
          end else begin
            if (w_href_fall) begin
              if (r_bytes != B_LINE) line_err <= 1'b1;
              r_y     <= w_y_close;
              r_x     <= '0;
              r_bytes <= '0;
              r_phase <= 1'b0;
            end
            if (r_href) begin
              if (w_href_rise)          r_bytes <= BW'(1);
              else if (r_bytes != B_SAT) r_bytes <= r_bytes + BW'(1);
              if (!w_phase) begin
                r_hi    <= r_data;
                r_phase <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                if (r_x != X_LIM) r_x <= r_x + XW'(1);
                if (w_store) begin
                  we    <= 1'b1;
                  waddr <= r_addr;
                  wdata <= w_pix;
                  if (r_addr != ADDR_MAX) r_addr <= r_addr + ADDR_W'(1);
                end
              end
            end
          end
        end
        default: r_state <= S_SYNC_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Scoreboard bench for ov7670_pixel_capture on a reduced 16x8 geometry (stored image 8x4).
module tb_ov7670_pixel_capture;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int D  = 2;
  localparam int AW = 8;
  localparam int OW = H / D;
  localparam int NP = OW * (V / D);

  logic          pclk = 1'b0;
  logic          reset, href, vsync;
  logic [7:0]    data;
  logic          we, frame_done, line_err, frame_err;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;
  logic [7:0]    frame_cnt;

  ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(D), .ADDR_W(AW)) dut (
    .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .data(data),
    .we(we), .waddr(waddr), .wdata(wdata), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .line_err(line_err), .frame_err(frame_err)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;
  int          frame_writes = 0;
  int          pushed = 0;
  logic [15:0] mem [0:NP-1];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the head of the expected queue.
  always @(negedge pclk) begin
    if (frame_done === 1'b1) done_count++;
    if (we === 1'b1) begin
      frame_writes++;
      if (waddr < NP) mem[waddr] = wdata;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we actual addr=%0d data=%h required no write", waddr, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.a !== waddr || mon_e.d !== wdata) begin
          errors++;
          $display("FAIL write actual addr=%0d data=%h required addr=%0d data=%h",
                   waddr, wdata, mon_e.a, mon_e.d);
        end else begin
          $display("write addr=%0d data=%h ok", waddr, wdata);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  function automatic logic [15:0] bar_colour(int p);
    int bar;
    bar = ((p / D) * 8) / OW;
    case (bar)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Send n lines; byte k of the frame is k[7:0] except the first pixel, which is F8,1F.
  task automatic lines(int n, int bad, bit cap);
    int          k = 0;
    int          ea = 0;
    int          nb;
    logic [7:0]  b0 = 8'h00;
    logic [7:0]  bv;
    logic [15:0] ed;
    for (int y = 0; y < n; y++) begin
      nb = (y == bad) ? 2 * H - 2 : 2 * H;
      for (int b = 0; b < nb; b++) begin
        bv = k[7:0];
        if (y == 0 && b == 0) bv = 8'hF8;
        if (y == 0 && b == 1) bv = 8'h1F;
        href = 1'b1;
        data = bv;
        if (b % 2 == 1) begin
          if (cap && ((b / 2) % D == 0) && (y % D == 0) && (b / 2 < H) && (y < V)) begin
`ifdef CAPTURE_TEST_PATTERN_EN
            ed = bar_colour(b / 2);
`else
            ed = {b0, bv};
`endif
            exp_q.push_back({AW'(ea), ed});
            ea++;
            pushed++;
          end
        end else begin
          b0 = bv;
        end
        k++;
        tick(1);
      end
      href = 1'b0;
      data = 8'h00;
      tick(4);
      if (y == bad) chk("line_err_after_short_line", line_err, 1);
    end
  endtask

  // Vsync pulse: outcome checked while vsync is high, flag clearing checked after it falls.
  task automatic pulse_check(string tag, int exp_cnt, int exp_done, bit exp_lerr, bit exp_ferr);
    vsync = 1'b1;
    tick(5);
    chk({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
    chk({tag, "_done_pulses"}, done_count, exp_done);
    chk({tag, "_line_err"}, line_err, exp_lerr);
    chk({tag, "_frame_err"}, frame_err, exp_ferr);
    chk({tag, "_write_count"}, frame_writes, pushed);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    vsync = 1'b0;
    tick(5);
    chk({tag, "_line_err_cleared"}, line_err, 0);
    chk({tag, "_frame_err_cleared"}, frame_err, 0);
    $display("frame %s closed cnt=%0d done=%0d", tag, frame_cnt, done_count);
    frame_writes = 0;
    pushed = 0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_line_err"}, line_err, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    href  = 1'b0;
    vsync = 1'b0;
    data  = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(1);
    check_reset_outputs("reset");

    pulse_check("sync", 0, 0, 0, 0);
    lines(8, -1, 0);                    // first frame after sync: never captured
    pulse_check("f1", 0, 0, 0, 0);
    lines(8, -1, 1);
    pulse_check("f2", 1, 1, 0, 0);
`ifdef CAPTURE_TEST_PATTERN_EN
    chk("pattern_addr0", mem[0], 16'hFFFF);
    chk("pattern_addr1", mem[1], 16'hFFE0);
    chk("pattern_addr7", mem[7], 16'h0000);
`else
    chk("pixel_0_0", mem[0], 16'hF81F);
    chk("pixel_2_0", mem[1], 16'h0405);
    chk("pixel_0_2", mem[OW], 16'h4041);
`endif
    lines(8, 3, 1);                     // one short line, still a full frame
    pulse_check("f3", 2, 2, 1, 0);
    lines(7, -1, 1);                    // one line short
    pulse_check("f4", 2, 2, 0, 1);
    lines(9, -1, 1);                    // one line too many
    pulse_check("f5", 2, 2, 0, 1);
    lines(8, -1, 1);
    pulse_check("f6", 3, 3, 0, 0);

    lines(4, -1, 1);                    // reset in the middle of a frame
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check_reset_outputs("midreset");
    lines(4, -1, 0);
    pulse_check("resync", 0, 3, 0, 0);
    lines(8, -1, 0);
    pulse_check("rearm", 0, 3, 0, 0);
    lines(8, -1, 1);
    pulse_check("f7", 1, 4, 0, 0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
